// File: rtl/cfg_task_sequencer.sv
// cfg_task_sequencer: walks a config array of task groups, unpacks beats
// into CSR writes, launches each task and waits for its completion.
// Ports: clk/rst, start/abort control, memory read request/data handshake,
// CSR write strobe/addr/data, task_start/task_done, busy/seq_done/aborted/task_cnt.
module cfg_task_sequencer #(
  parameter int CFG_DW     = 512,
  parameter int REG_DW     = 32,
  parameter int REG_AW     = 8,
  parameter int BASE_BEATS = 2,
  parameter int ADDR_W     = 32,
  parameter int TASK_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [TASK_W-1:0] task_num,
  input  logic [TASK_W-1:0] aux_group_num,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_dat_valid,
  output logic              rd_dat_ready,
  input  logic [CFG_DW-1:0] rd_dat,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [REG_DW-1:0] reg_wr_dat,
  output logic              task_start,
  input  logic              task_done,
  output logic              busy,
  output logic              seq_done,
  output logic              aborted,
  output logic [TASK_W-1:0] task_cnt
);

  localparam int L  = CFG_DW / REG_DW;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int BW = TASK_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(CFG_DW / 8);
  localparam logic [LW-1:0] LAST = LW'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RECV, S_UNPACK, S_LAUNCH, S_WAIT, S_FIN
  } state_t;

  state_t            state;
  logic [TASK_W-1:0] num_q;
  logic [BW-1:0]     bpg_q;
  logic [BW-1:0]     beat;
  logic [LW-1:0]     lane;
  logic [REG_AW-1:0] waddr;
  logic [CFG_DW-1:0] data_q;
  logic              abort_q;

  // rd_req_addr doubles as the beat pointer; it only matters while
  // rd_req_valid is high, so advancing it at the handshake is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      num_q        <= '0;
      bpg_q        <= '0;
      beat         <= '0;
      lane         <= '0;
      waddr        <= '0;
      data_q       <= '0;
      abort_q      <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_dat_ready <= 1'b0;
      reg_wr_en    <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_dat   <= '0;
      task_start   <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      aborted      <= 1'b0;
      task_cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            aborted     <= 1'b0;
            abort_q     <= 1'b0;
            task_cnt    <= '0;
            rd_req_addr <= cfg_base_addr;
            num_q       <= task_num;
            bpg_q       <= BW'(BASE_BEATS) + BW'(aux_group_num);
            beat        <= '0;
            waddr       <= '0;
            if (task_num == '0) begin
              state    <= S_FIN;
              seq_done <= 1'b1;
            end else begin
              state        <= S_REQ;
              rd_req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (rd_req_ready) begin
            // a read already in flight must be drained before FIN
            rd_req_valid <= 1'b0;
            rd_dat_ready <= 1'b1;
            rd_req_addr  <= rd_req_addr + STEP;
            abort_q      <= abort;
            state        <= S_RECV;
          end else if (abort) begin
            rd_req_valid <= 1'b0;
            seq_done     <= 1'b1;
            aborted      <= 1'b1;
            state        <= S_FIN;
          end
        end
        S_RECV: begin
          if (abort) abort_q <= 1'b1;
          if (rd_dat_valid) begin
            rd_dat_ready <= 1'b0;
            if (abort || abort_q) begin
              seq_done <= 1'b1;
              aborted  <= 1'b1;
              state    <= S_FIN;
            end else begin
              reg_wr_en   <= 1'b1;
              reg_wr_addr <= waddr;
              reg_wr_dat  <= rd_dat[REG_DW-1:0];
              data_q      <= {{REG_DW{1'b0}}, rd_dat[CFG_DW-1:REG_DW]};
              waddr       <= waddr + 1'b1;
              lane        <= '0;
              state       <= S_UNPACK;
            end
          end
        end
        S_UNPACK: begin
          if (abort) begin
            reg_wr_en <= 1'b0;
            seq_done  <= 1'b1;
            aborted   <= 1'b1;
            state     <= S_FIN;
          end else if (lane == LAST) begin
            reg_wr_en <= 1'b0;
            if ((beat + 1'b1) < bpg_q) begin
              beat         <= beat + 1'b1;
              rd_req_valid <= 1'b1;
              state        <= S_REQ;
            end else begin
              task_start <= 1'b1;
              state      <= S_LAUNCH;
            end
          end else begin
            reg_wr_addr <= waddr;
            reg_wr_dat  <= data_q[REG_DW-1:0];
            data_q      <= {{REG_DW{1'b0}}, data_q[CFG_DW-1:REG_DW]};
            waddr       <= waddr + 1'b1;
            lane        <= lane + 1'b1;
          end
        end
        S_LAUNCH: begin
          task_start <= 1'b0;
          if (abort) begin
            seq_done <= 1'b1;
            aborted  <= 1'b1;
            state    <= S_FIN;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (task_done) begin
            task_cnt <= task_cnt + 1'b1;
            beat     <= '0;
            waddr    <= '0;
          end
          if (abort) begin
            seq_done <= 1'b1;
            aborted  <= 1'b1;
            state    <= S_FIN;
          end else if (task_done) begin
            if ((task_cnt + 1'b1) == num_q) begin
              seq_done <= 1'b1;
              state    <= S_FIN;
            end else begin
              rd_req_valid <= 1'b1;
              state        <= S_REQ;
            end
          end
        end
        S_FIN: begin
          seq_done <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cfg_task_sequencer.md
Name: cfg_task_sequencer

Overview:
- Hardware replacement for the bench-side CFG driver loop.
- Walks a configuration array in memory: N task groups, each made of base register beats plus a runtime number of auxiliary beats.
- Unpacks each wide beat into 32-bit register writes for the accelerator CSR file (MVM/BN/Res/activation), then pulses task start and waits for task done before fetching the next group.
- Sits between the host CSR block and the memory read port on the `clk` domain.

Parameters:
- CFG_DW, 512, width of one config beat (= AXI data width).
- REG_DW, 32, width of one CSR write.
- REG_AW, 8, CSR write address width.
- BASE_BEATS, 2, fixed beats per task group (base CSR set = BASE_BEATS*CFG_DW/REG_DW registers).
- ADDR_W, 32, memory byte address width.
- TASK_W, 16, width of task and aux-group counts.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle launch pulse; sampled only in IDLE
- abort  in  1  one-cycle abort pulse
- cfg_base_addr  in  ADDR_W  byte address of beat 0 (CFG_DW/8 aligned)
- task_num  in  TASK_W  number of task groups (max_tasks_num)
- aux_group_num  in  TASK_W  extra beats per group (Aux_Reg_Group_Nums)
- rd_req_valid  out  1  read request valid
- rd_req_ready  in  1  read request accepted
- rd_req_addr  out  ADDR_W  beat byte address
- rd_dat_valid  in  1  read data valid
- rd_dat_ready  out  1  read data accept
- rd_dat  in  CFG_DW  read beat
- reg_wr_en  out  1  CSR write strobe
- reg_wr_addr  out  REG_AW  CSR word address
- reg_wr_dat  out  REG_DW  CSR data
- task_start  out  1  one-cycle task launch pulse
- task_done  in  1  task completion pulse
- busy  out  1  high outside IDLE
- seq_done  out  1  one-cycle pulse at the end of a sequence
- aborted  out  1  set with seq_done when ended by abort; held until next start
- task_cnt  out  TASK_W  completed task count

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Derived constants:
  - L = CFG_DW/REG_DW (16 registers per beat).
  - Beats per group BPG = BASE_BEATS + aux_group_num, latched at start together with cfg_base_addr and task_num.
- States: IDLE, REQ, RECV, UNPACK, LAUNCH, WAIT, FIN.
- IDLE:
  - start with task_num=0 -> FIN; seq_done pulses on the next cycle, and no reads are issued.
  - start with task_num>0 -> REQ; ptr=cfg_base_addr, beat=0, task_cnt=0, aborted=0.
- REQ:
  - rd_req_valid=1 and rd_req_addr=ptr, held stable until rd_req_ready.
  - On handshake -> RECV; ptr += CFG_DW/8.
  - Only one outstanding read at a time.
- RECV:
  - rd_dat_ready=1; beat captured on rd_dat_valid -> UNPACK.
- UNPACK:
  - Emits L writes on L consecutive cycles, lane k = rd_dat[k*REG_DW +: REG_DW], LSB lane first.
  - reg_wr_addr = beat*L + k, truncated to REG_AW.
  - After lane L-1: if beat < BPG-1, then beat++ -> REQ; else -> LAUNCH.
- LAUNCH:
  - task_start=1 for exactly one cycle -> WAIT.
- WAIT:
  - On task_done: task_cnt++ and beat=0.
  - If task_cnt+1 == task_num -> FIN, else -> REQ.
  - task_done outside WAIT is ignored.
- FIN:
  - seq_done=1 for one cycle -> IDLE.
- start while busy: ignored.
- Abort:
  - Latches an abort flag in any non-IDLE state.
  - In REQ before the handshake: drop rd_req_valid -> FIN.
  - In RECV: accept the pending beat, discard it -> FIN.
  - In UNPACK: stop writes on the next cycle -> FIN.
  - In LAUNCH or WAIT: -> FIN without waiting for task_done.
  - aborted=1 together with seq_done.
  - abort in IDLE: no effect.
- Simultaneous abort and task_done in WAIT: abort wins; task_cnt still increments.
- Address wrap: ptr wraps modulo 2^ADDR_W.
- reg_wr_addr: wraps silently when BPG*L > 2^REG_AW.
- Latency: task_start of group 0 comes (rd_req_ready delay + rd_dat delay + L + 2)*BPG cycles minimum after start.
- Async reset mid-operation: immediate return to IDLE with all outputs 0; any in-flight read data is ignored.

Test Plan:
- Reset mid-UNPACK (assert rst during write 5) -> reg_wr_en, busy, task_start go 0 immediately; state IDLE; the next start behaves normally.
- start, task_num=1, aux=0, base 0x500_0000, beats with lane k = k+0x100*beat -> reads at 0x500_0000 and 0x500_0040; 32 writes addr 0..31, data 0x0..0xF then 0x100..0x10F; one task_start; seq_done after task_done; task_cnt=1.
- task_num=3, aux=1 -> 9 reads at base+0x40*i for i=0..8; writes addr 0..47 per task; 3 task_start pulses, each only after the prior task_done; task_cnt=3.
- task_num=0 -> no rd_req_valid; seq_done one cycle after start; busy high for exactly 1 cycle.
- rd_req_ready held low 7 cycles, rd_dat_valid delayed 4 cycles -> rd_req_addr stable throughout; no duplicate request; write data unaffected.
- abort in WAIT of task 2 of 4 -> seq_done and aborted=1 next cycle; task_cnt=1; a later task_done is ignored; start while busy is ignored throughout.
